// File: rtl/ne_serial_ctrl.sv
// ne_serial_ctrl -- multi-cycle WIDTH-bit not-equal sequencer.
//
// Compares A and B CHUNK bits per cycle, LSB chunk first, so a narrow NE
// slice can be reused instead of a full-width OR chain. Operand pairs come in
// over a valid/ready handshake; the result (Y = A != B, plus the index of the
// lowest differing chunk) is held on out_valid until out_ready.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid           in_ready   pair accepted (IDLE only)
//   A, B       WIDTH-bit operands, sampled on accept
//   out_valid  result valid (DONE)          out_ready  consumer takes result
//   Y          1 when A != B                diff_idx   lowest mismatching chunk
//   busy       controller not in IDLE
//
// Optional feature: define NE_EARLY_EXIT_EN to finish on the first mismatching
// chunk. Left undefined, latency is a fixed NCHUNK cycles (data-independent).
module ne_serial_ctrl #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4,
  localparam int NCHUNK = WIDTH / CHUNK,
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             Y,
  output logic [CW-1:0]    diff_idx,
  output logic             busy
);

  if ((CHUNK < 1) || (CHUNK > WIDTH) || ((WIDTH % CHUNK) != 0)) begin : g_bad_param
    $error("ne_serial_ctrl: CHUNK must divide WIDTH and lie in 1..WIDTH");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             acc_q, acc_d;
  logic             found_q, found_d;
  logic [CW-1:0]    idx_q, idx_d;

  logic m;
  logic last;

  // Mismatch in the chunk currently at the bottom of the shift registers.
  assign m    = |(a_sh_q[CHUNK-1:0] ^ b_sh_q[CHUNK-1:0]);
  assign last = (cnt_q == CW'(NCHUNK - 1));

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    found_d = found_q;
    idx_d   = idx_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_sh_d  = A;
          b_sh_d  = B;
          cnt_d   = '0;
          acc_d   = 1'b0;
          found_d = 1'b0;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Only the first mismatching chunk records its index.
        if (m && !found_q) begin
          idx_d   = cnt_q;
          found_d = 1'b1;
        end
        acc_d  = acc_q | m;
        a_sh_d = a_sh_q >> CHUNK;
        b_sh_d = b_sh_q >> CHUNK;
        // Saturate on the last chunk so the counter never wraps.
        cnt_d  = last ? cnt_q : cnt_q + CW'(1);
        if (last) state_d = S_DONE;
`ifdef NE_EARLY_EXIT_EN
        if (m) state_d = S_DONE;
`endif
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b0;
      found_q <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      found_q <= found_d;
      idx_q   <= idx_d;
    end
  end

  // in_ready is gated by rst so nothing is accepted while reset is held.
  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign Y         = acc_q;
  assign diff_idx  = idx_q;

endmodule
